// File: rtl/demux_pkg.sv
// Shared defaults and selector extraction for the 1-to-N packet demultiplexer.
package demux_pkg;

    localparam int DATA_W_DEF     = 6;
    localparam int NUM_CH_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ERR_CNT_W      = 8;

    // Widest selector (NUM_CH <= 8) and widest word the helper accepts.
    localparam int SEL_MAX_W  = 3;
    localparam int WORD_MAX_W = 64;

    function automatic logic [SEL_MAX_W-1:0] sel_of(
        input logic [WORD_MAX_W-1:0] word,
        input int unsigned           data_w,
        input int unsigned           sel_w
    );
        logic [WORD_MAX_W-1:0] shifted;
        logic [SEL_MAX_W:0]    mask;
        shifted = word >> (data_w - sel_w);
        mask    = (4'd1 << sel_w) - 4'd1;
        return shifted[SEL_MAX_W-1:0] & mask[SEL_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-channel synchronous FIFO; the head word reads as zero while empty.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_s, pop_s;

    // Status flags, guarded push/pop and head word.
    always_comb begin
        full      = (cnt_q == DEPTH_C);
        empty     = (cnt_q == '0);
        push_s    = push && !full;
        pop_s     = pop && !empty;
        head_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_s && (wr_ptr_q == PTR_W'(i))) ? push_data : mem_q[i];
        end
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE_C;
            2'b01:   cnt_d = cnt_q - CNT_ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards every buffered word at once.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_nch.sv
// 1-to-N packet demultiplexer: routes each word by its top SEL_W bits into a
// per-channel FIFO, with backpressure on full channels and out-of-range drop accounting.
module demux_nch
    import demux_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SEL_W      = $clog2(NUM_CH),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        valid_out,
    input  logic [NUM_CH-1:0]        ready_in,
    output logic                     sel_err,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam logic [SEL_MAX_W:0]   NUM_CH_C  = (SEL_MAX_W+1)'(NUM_CH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX_C = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE_C = ERR_CNT_W'(1);

    logic [WORD_MAX_W-1:0] word_ext_s;
    logic [SEL_MAX_W-1:0]  sel_s;
    logic                  in_range_s;
    logic [NUM_CH-1:0]     hit_s;
    logic [NUM_CH-1:0]     full_s;
    logic [NUM_CH-1:0]     empty_s;
    logic [NUM_CH-1:0]     push_s;
    logic [NUM_CH-1:0]     pop_s;
    logic                  accept_s;
    logic                  drop_s;
    logic [DATA_W-1:0]     head_s [NUM_CH];

    logic                  sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // Selector decode into a one-hot channel hit; out-of-range words hit nothing.
    always_comb begin
        word_ext_s = WORD_MAX_W'(data_in);
        sel_s      = sel_of(word_ext_s, DATA_W, SEL_W);
        in_range_s = ({1'b0, sel_s} < NUM_CH_C);
        hit_s      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit_s[c] = in_range_s && (sel_s == SEL_MAX_W'(c));
        end
    end

    // Accept depends only on the addressed channel's full flag, never on a same-cycle pop.
    always_comb begin
        ready_out = ~|(hit_s & full_s);
        accept_s  = valid_in && ready_out;
        push_s    = hit_s & {NUM_CH{accept_s}};
        drop_s    = accept_s && !in_range_s;
        pop_s     = ready_in & ~empty_s;
    end

    // Drop pulse and saturating drop counter next-state.
    always_comb begin
        sel_err_d = drop_s;
        err_cnt_d = (drop_s && (err_cnt_q != ERR_MAX_C)) ? (err_cnt_q + ERR_ONE_C) : err_cnt_q;
    end

    // Error pulse and counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;
    assign valid_out = ~empty_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_L   (reset_L),
            .push      (push_s[g]),
            .push_data (data_in),
            .pop       (pop_s[g]),
            .head_data (head_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g])
        );
        assign data_out[g*DATA_W +: DATA_W] = head_s[g];
    end

endmodule

// File: tb/tb_demux_nch.sv
// Directed bench for demux_nch: a 2-channel and a 3-channel instance share clock and reset.
module tb_demux_nch;

    logic clk = 1'b0;
    logic reset_L;

    logic        valid_in2, ready_out2, sel_err2;
    logic [5:0]  data_in2;
    logic [11:0] data_out2;
    logic [1:0]  valid_out2, ready_in2;
    logic [7:0]  err_cnt2;

    logic        valid_in3, ready_out3, sel_err3;
    logic [5:0]  data_in3;
    logic [17:0] data_out3;
    logic [2:0]  valid_out3, ready_in3;
    logic [7:0]  err_cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_nch #(.DATA_W(6), .NUM_CH(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in2), .data_in(data_in2),
        .ready_out(ready_out2), .data_out(data_out2), .valid_out(valid_out2),
        .ready_in(ready_in2), .sel_err(sel_err2), .err_cnt(err_cnt2)
    );

    demux_nch #(.DATA_W(6), .NUM_CH(3), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in3), .data_in(data_in3),
        .ready_out(ready_out3), .data_out(data_out3), .valid_out(valid_out3),
        .ready_in(ready_in3), .sel_err(sel_err3), .err_cnt(err_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [5:0] w;
        logic [5:0] bp_words [5];
        bp_words[0] = 6'h21; bp_words[1] = 6'h22; bp_words[2] = 6'h23;
        bp_words[3] = 6'h24; bp_words[4] = 6'h25;

        reset_L = 1'b0;
        valid_in2 = 1'b0; data_in2 = 6'h00; ready_in2 = 2'b00;
        valid_in3 = 1'b0; data_in3 = 6'h00; ready_in3 = 3'b000;
        #13;
        check("rst_valid2", 32'(valid_out2), 32'h0);
        check("rst_data2", 32'(data_out2), 32'h0);
        check("rst_errcnt3", 32'(err_cnt3), 32'h0);
        check("rst_selerr3", 32'(sel_err3), 32'h0);
        reset_L = 1'b1;
        tick;
        check("idle_ready2", 32'(ready_out2), 32'h1);

        // Routing: 0x25 has bit5 set -> ch1, 0x0A -> ch0
        valid_in2 = 1'b1; data_in2 = 6'h25;
        tick;
        check("route1_valid", 32'(valid_out2), 32'h2);
        check("route1_data", 32'(data_out2), 32'h940);
        data_in2 = 6'h0A;
        tick;
        valid_in2 = 1'b0;
        check("route2_valid", 32'(valid_out2), 32'h3);
        check("route2_data", 32'(data_out2), 32'h94A);
        check("route_errcnt", 32'(err_cnt2), 32'h0);
        ready_in2 = 2'b11;
        tick;
        ready_in2 = 2'b00;
        check("drain_valid", 32'(valid_out2), 32'h0);
        check("drain_data", 32'(data_out2), 32'h0);

        // Backpressure on ch1 with depth 4
        for (int i = 0; i < 4; i++) begin
            valid_in2 = 1'b1; data_in2 = bp_words[i];
            #1;
            check("bp_ready_fill", 32'(ready_out2), 32'h1);
            tick;
        end
        data_in2 = bp_words[4];
        #1;
        check("bp_ready_full", 32'(ready_out2), 32'h0);
        check("bp_head", 32'(data_out2[11:6]), 32'h21);
        tick;
        check("bp_held", 32'(ready_out2), 32'h0);
        ready_in2 = 2'b10;
        #1;
        check("bp_ready_ignores_pop", 32'(ready_out2), 32'h0);
        tick;
        ready_in2 = 2'b00;
        #1;
        check("bp_ready_after_pop", 32'(ready_out2), 32'h1);
        tick;
        valid_in2 = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check("bp_order", 32'(data_out2[11:6]), 32'(bp_words[i]));
            ready_in2 = 2'b10;
            tick;
        end
        ready_in2 = 2'b00;
        check("bp_empty", 32'(valid_out2), 32'h0);

        // Streaming into ch0 with concurrent pop, pointers wrap
        for (int i = 0; i < 10; i++) begin
            w = 6'h10 + 6'(i);
            valid_in2 = 1'b1; data_in2 = w; ready_in2 = 2'b01;
            #1;
            check("stream_ready", 32'(ready_out2), 32'h1);
            tick;
            check("stream_valid", 32'(valid_out2), 32'h1);
            check("stream_data", 32'(data_out2[5:0]), 32'(w));
        end
        valid_in2 = 1'b0;
        tick;
        ready_in2 = 2'b00;
        check("stream_empty", 32'(valid_out2), 32'h0);

        // Invalid selector on the 3-channel instance
        valid_in3 = 1'b1; data_in3 = 6'b11_0001;
        #1;
        check("inv_ready", 32'(ready_out3), 32'h1);
        tick;
        valid_in3 = 1'b0;
        check("inv_selerr", 32'(sel_err3), 32'h1);
        check("inv_errcnt", 32'(err_cnt3), 32'h1);
        check("inv_novalid", 32'(valid_out3), 32'h0);
        check("inv_nodata", 32'(data_out3), 32'h0);
        valid_in3 = 1'b1; data_in3 = 6'h27;
        tick;
        valid_in3 = 1'b0;
        check("inv_pulse_end", 32'(sel_err3), 32'h0);
        check("ch2_valid", 32'(valid_out3), 32'h4);
        check("ch2_data", 32'(data_out3), 32'h27000);
        for (int i = 0; i < 300; i++) begin
            valid_in3 = 1'b1; data_in3 = 6'h31;
            tick;
        end
        check("sat_errcnt", 32'(err_cnt3), 32'hFF);
        check("sat_selerr", 32'(sel_err3), 32'h1);
        valid_in3 = 1'b0;
        tick;
        check("sat_hold", 32'(err_cnt3), 32'hFF);
        check("sat_pulse_end", 32'(sel_err3), 32'h0);
        check("sat_ch2_kept", 32'(data_out3[17:12]), 32'h27);

        // Reset mid-stream: ch0 holds 3 words, ch1 holds 2
        valid_in2 = 1'b1;
        data_in2 = 6'h01; tick;
        data_in2 = 6'h31; tick;
        data_in2 = 6'h02; tick;
        data_in2 = 6'h32; tick;
        data_in2 = 6'h03; tick;
        valid_in2 = 1'b0;
        check("pre_rst_valid", 32'(valid_out2), 32'h3);
        check("pre_rst_data", 32'(data_out2), 32'hC41);
        #1;
        reset_L = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_out2), 32'h0);
        check("mid_rst_data", 32'(data_out2), 32'h0);
        check("mid_rst_errcnt3", 32'(err_cnt3), 32'h0);
        check("mid_rst_valid3", 32'(valid_out3), 32'h0);
        #1;
        reset_L = 1'b1;
        tick;
        valid_in2 = 1'b1; data_in2 = 6'h2A;
        tick;
        valid_in2 = 1'b0;
        check("post_rst_valid", 32'(valid_out2), 32'h2);
        check("post_rst_data", 32'(data_out2), 32'hA80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
